// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - opcode constants and 2-bit counter helpers for the fetch-stage predictor
package npc_pkg;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [4:0] RT_BLTZ = 5'b00000;
   localparam logic [4:0] RT_BGEZ = 5'b00001;

   typedef logic [1:0] cnt_t;

   localparam cnt_t SNT = 2'b00;
   localparam cnt_t WNT = 2'b01;
   localparam cnt_t WT  = 2'b10;
   localparam cnt_t ST  = 2'b11;

   // Saturating step toward the resolved outcome.
   function automatic cnt_t cnt_step(input cnt_t c, input logic taken);
      if (taken)
         return (c == ST) ? ST : c + 2'd1;
      else
         return (c == SNT) ? SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/npc_bht.sv
// rtl/npc_bht.sv - branch history table of 2-bit saturating counters
module npc_bht
   import npc_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX     = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [IDX-1:0] rd_idx_i,
   output logic           rd_taken_o,
   input  logic           upd_en_i,
   input  logic [IDX-1:0] upd_idx_i,
   input  logic           upd_taken_i
);

   cnt_t cnt_q [ENTRIES];
   cnt_t cnt_d [ENTRIES];

   always_comb begin
      cnt_d = cnt_q;
      if (upd_en_i)
         cnt_d[upd_idx_i] = cnt_step(cnt_q[upd_idx_i], upd_taken_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++)
            cnt_q[i] <= WNT;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Read sees the pre-update counter; a same-cycle update lands next cycle.
   assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/npc_predict.sv
// rtl/npc_predict.sv - fetch PC register with predecode, BHT prediction and EX redirect
module npc_predict
   import npc_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               BHT_ENTRIES = 16,
   parameter logic [WIDTH-1:0] RESET_PC    = 'h0000_3000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [31:0]      if_instr,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jumpr,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic             ex_taken,
   input  logic             ex_pred_taken,
   input  logic [WIDTH-1:0] ex_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             pred_taken,
   output logic             flush
);

   localparam int IDX = $clog2(BHT_ENTRIES);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [5:0]       opcode;
   logic [4:0]       rt;
   logic             is_jump, is_branch, bht_taken, redirect;
   logic [WIDTH-1:0] imm_sext, jump_target, branch_target, pred_next, redirect_target;

   assign opcode = if_instr[31:26];
   assign rt     = if_instr[20:16];

   always_comb begin
      is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
      is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                  (opcode == OP_BLEZ) || (opcode == OP_BGTZ) ||
                  ((opcode == OP_REGIMM) && ((rt == RT_BLTZ) || (rt == RT_BGEZ)));
   end

   npc_bht #(
      .ENTRIES (BHT_ENTRIES),
      .IDX     (IDX)
   ) u_bht (
      .clk_i       (clk),
      .rst_i       (rst),
      .rd_idx_i    (pc_q[IDX+1:2]),
      .rd_taken_o  (bht_taken),
      .upd_en_i    (ex_valid & ex_is_branch),
      .upd_idx_i   (ex_pc[IDX+1:2]),
      .upd_taken_i (ex_taken)
   );

   assign pc_plus4      = pc_q + WIDTH'(4);
   assign imm_sext      = {{(WIDTH-18){if_instr[15]}}, if_instr[15:0], 2'b00};
   assign branch_target = pc_plus4 + imm_sext;
   assign jump_target   = {pc_plus4[WIDTH-1:28], if_instr[25:0], 2'b00};
   assign pred_taken    = is_branch & bht_taken;

   always_comb begin
      pred_next = pc_plus4;
      if (is_jump)
         pred_next = jump_target;
      else if (pred_taken)
         pred_next = branch_target;
   end

   // Only a wrong branch guess or an indirect jump forces recovery from EX.
   assign redirect        = ex_valid & ((ex_is_branch & (ex_taken ^ ex_pred_taken)) | ex_is_jumpr);
   assign redirect_target = (ex_taken | ex_is_jumpr) ? ex_target : ex_pc + WIDTH'(4);
   assign flush           = redirect;

   always_comb begin
      pc_d = pred_next;
      if (redirect)
         pc_d = redirect_target;
      else if (stall)
         pc_d = pc_q;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc = pc_q;

   a_ex_kind_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(ex_is_branch && ex_is_jumpr));

endmodule

// File: tb/tb_npc_predict.sv
// tb/tb_npc_predict.sv - scoreboard bench for npc_predict against a behavioural model
module tb_npc_predict;

   logic        clk = 1'b0;
   logic        rst, stall, ex_valid, ex_is_branch, ex_is_jumpr, ex_taken, ex_pred_taken;
   logic [31:0] if_instr, ex_pc, ex_target;
   logic [31:0] pc, pc_plus4;
   logic        pred_taken, flush;

   always #5 clk = ~clk;

   npc_predict dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .if_instr      (if_instr),
      .ex_valid      (ex_valid),
      .ex_is_branch  (ex_is_branch),
      .ex_is_jumpr   (ex_is_jumpr),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_pred_taken (ex_pred_taken),
      .ex_target     (ex_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .pred_taken    (pred_taken),
      .flush         (flush)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        pt;
      logic        fl;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] pc_m;
   int          bht_m[16];

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] BEQ4 = 32'h1000_0004;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_pc", pc, e.pc);
         chk("sb_pc_plus4", pc_plus4, e.pc4);
         chk("sb_pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
         chk("sb_flush", {31'd0, flush}, {31'd0, e.fl});
      end
   end

   task automatic model_reset();
      pc_m = 32'h0000_3000;
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
   endtask

   task automatic step(input logic r, input logic s, input logic [31:0] instr,
                       input logic ev, input logic eb, input logic ej, input logic [31:0] epc,
                       input logic et, input logic ept, input logic [31:0] etg);
      exp_t        e;
      logic [31:0] p4, nxt, tgt;
      int          op, rtf, off, bi;
      logic        ptk, redir;
      @(posedge clk);
      #1;
      rst = r; stall = s; if_instr = instr; ex_valid = ev; ex_is_branch = eb;
      ex_is_jumpr = ej; ex_pc = epc; ex_taken = et; ex_pred_taken = ept; ex_target = etg;
      p4  = pc_m + 32'd4;
      op  = int'(instr[31:26]);
      rtf = int'(instr[20:16]);
      ptk = 1'b0;
      nxt = p4;
      if (op == 2 || op == 3) begin
         nxt = (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
      end else if ((op >= 4 && op <= 7) || (op == 1 && rtf <= 1)) begin
         ptk = (bht_m[(pc_m >> 2) % 16] >= 2);
         off = int'($signed(instr[15:0]));
         if (ptk) nxt = p4 + 32'(off * 4);
      end
      redir = ev && ((eb && (et != ept)) || ej);
      tgt   = (et || ej) ? etg : epc + 32'd4;
      e.pc = pc_m; e.pc4 = p4; e.pt = ptk; e.fl = redir;
      exp_q.push_back(e);
      if (r) begin
         model_reset();
      end else begin
         if (ev && eb) begin
            bi = int'((epc >> 2) % 16);
            bht_m[bi] = et ? ((bht_m[bi] < 3) ? bht_m[bi] + 1 : 3)
                           : ((bht_m[bi] > 0) ? bht_m[bi] - 1 : 0);
         end
         if (redir)  pc_m = tgt;
         else if (!s) pc_m = nxt;
      end
   endtask

   task automatic nop(input logic s);
      step(1'b0, s, NOP, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] instr, epc, etg;
      logic        r, s, ev, eb, ej, et, ept;
      int          k;
      rst = 1'b1; stall = 1'b0; if_instr = NOP; ex_valid = 1'b0; ex_is_branch = 1'b0;
      ex_is_jumpr = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_target = 32'd0;
      repeat (2) @(posedge clk);
      model_reset();

      // reset state and untrained beq
      step(1'b1, 1'b0, BEQ4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, BEQ4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("t1_pc", pc, 32'h3000);
      chk("t1_flush", {31'd0, flush}, 32'd0);
      chk("t1_pred", {31'd0, pred_taken}, 32'd0);

      // stall holds 0x3004 for two cycles
      nop(1'b1); #1 chk("t2_hold0", pc, 32'h3004);
      nop(1'b1); #1 chk("t2_hold1", pc, 32'h3004);
      nop(1'b0); #1 chk("t2_hold2", pc, 32'h3004);
      nop(1'b0); #1 chk("t2_adv", pc, 32'h3008);

      // J redirects immediately
      do_reset();
      step(1'b0, 1'b0, 32'h0800_0C10, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("t3_pc", pc, 32'h3000);
      chk("t3_pred", {31'd0, pred_taken}, 32'd0);
      chk("t3_flush", {31'd0, flush}, 32'd0);
      nop(1'b0); #1 chk("t3_target", pc, 32'h3040);

      // train 0x3010 to strongly taken, then fetch beq there
      do_reset();
      step(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h3020);
      step(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h3020);
      nop(1'b0);
      nop(1'b0);
      step(1'b0, 1'b0, BEQ4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("t4_pc", pc, 32'h3010);
      chk("t4_pred", {31'd0, pred_taken}, 32'd1);
      nop(1'b0); #1 chk("t4_target", pc, 32'h3024);

      // mispredict recovery wins over stall
      step(1'b0, 1'b1, NOP, 1'b1, 1'b1, 1'b0, 32'h3010, 1'b0, 1'b1, 32'h3020);
      #1 chk("t5_flush", {31'd0, flush}, 32'd1);
      nop(1'b0); #1 chk("t5_pc", pc, 32'h3014);

      // jr redirect, then jr colliding with reset
      step(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b1, 32'h3020, 1'b0, 1'b0, 32'h3100);
      #1 chk("t6_flush", {31'd0, flush}, 32'd1);
      nop(1'b0); #1 chk("t6_pc", pc, 32'h3100);
      step(1'b1, 1'b0, NOP, 1'b1, 1'b0, 1'b1, 32'h3020, 1'b0, 1'b0, 32'h3100);
      nop(1'b0); #1 chk("t6_rst_pc", pc, 32'h3000);
      nop(1'b0);
      nop(1'b0);
      nop(1'b0);
      step(1'b0, 1'b0, BEQ4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1 chk("t6_bht_reset", {31'd0, pred_taken}, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 63) == 0);
         s = ($urandom_range(0, 4) == 0);
         instr = $urandom;
         k = $urandom_range(0, 5);
         case (k)
            0: instr[31:26] = 6'($urandom_range(2, 3));
            1, 2: instr[31:26] = 6'($urandom_range(4, 7));
            3: begin instr[31:26] = 6'd1; instr[20:16] = 5'($urandom_range(0, 3)); end
            default: ;
         endcase
         ev  = ($urandom_range(0, 2) == 0);
         k   = $urandom_range(0, 3);
         eb  = (k <= 1);
         ej  = (k == 2);
         epc = {26'h0000_00C, 4'($urandom), 2'b00};
         et  = 1'($urandom);
         ept = 1'($urandom);
         etg = {$urandom} & 32'hFFFF_FFFC;
         step(r, s, instr, ev, eb, ej, epc, et, ept, etg);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
